rtc_bus_seq: RTL and testbench
==============================

# rtc_bus_seq

Bus-master sequencer that shares the RTC register bank between three on-chip requesters: the servo (time offset), the frequency loop (tick increment) and the time-read client (current-time snapshot). It sits between those clients and the 32-bit bus2ip slave port of the RTC block. It turns each request into the ordered register accesses the bank requires, and spaces successive sequences so that self-clearing control bits settle.

## Interface
Parameters:
- BASE, `RTC_BLK_ADDR: 24-bit RTC block base, driven on m_addr_o[31:8].
- GUARD_CYC, 4: idle cycles after each sequence (min 3, covers the self-clear pipeline).

Ports:
- bus2ip_clk  in  1  clock; one clock domain.
- bus2ip_rst_n  in  1  reset, asynchronous, active-low.
- ofs_req_i  in  1  offset request, level, held until ofs_ack_o.
- ofs_sc_i  in  48  seconds offset.
- ofs_ns_i  in  32  nanoseconds offset.
- intxms_sel_i  in  1  value written to the intxms_sel bit on every RTC_CTL write.
- ofs_ack_o  out  1  one-cycle pulse when the offset sequence is done.
- inc_req_i  in  1  tick-increment request, level.
- inc_val_i  in  32  tick increment (6.26 ns).
- inc_ack_o  out  1  one-cycle done pulse.
- rd_req_i  in  1  time-read request, level.
- rd_ack_o  out  1  one-cycle pulse; rd_std_o and rd_fns_o are valid from this cycle.
- rd_std_o  out  80  captured seconds[79:32] and ns[31:0].
- rd_fns_o  out  16  captured fractional ns.
- m_addr_o  out  32  bus address.
- m_data_o  out  32  bus write data.
- m_wr_ce_o  out  1  write strobe, active high, one cycle per access.
- m_rd_ce_o  out  1  read strobe, active high.
- m_data_i  in  32  slave read data, registered: valid the cycle after m_rd_ce_o.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Offsets are `NS_OFST_ADDR, `SC_OFST_ADDR0/1, `RTC_CTL_ADDR, `TICK_INC_ADDR and `CUR_TM_ADDR0..2 from ptpv2_defines.v, placed on m_addr_o[7:0]. m_addr_o[31:8] = BASE.
- States: IDLE, OFS_NS, OFS_SC0, OFS_SC1, OFS_CTL, INC_WR, RD0, RD1, RD2, RD_CAP, GUARD.
- Arbitration happens only in IDLE, with fixed priority ofs > inc > rd.
- Payload (ofs_sc_i, ofs_ns_i, inc_val_i, intxms_sel_i) is latched at grant. Later input changes do not affect the running sequence.
- A request dropped before grant is ignored.
- Offset sequence, one write per state:
  - OFS_NS writes ns.
  - OFS_SC0 writes sc[47:16].
  - OFS_SC1 writes {16'h0, sc[15:0]}.
  - OFS_CTL writes {29'h0, intxms_sel, 1'b0, 1'b1}.
  - Then GUARD.
- Increment sequence: INC_WR writes inc_val, then GUARD.
- Read sequence: RD0..RD2 read CUR_TM_ADDR0..2; RD_CAP takes the last capture; then GUARD.
  - Word0 -> rd_std_o[79:48]; word1 -> [47:16]; word2[31:16] -> [15:0]; word2[15:0] -> rd_fns_o.
  - Reads are non-atomic; coherence across the three words is the client's responsibility.
  - rd_std_o/rd_fns_o update only at sequence completion and are held otherwise.
- GUARD counts GUARD_CYC cycles and then returns to IDLE.
- A requester still asserted after its ack starts a new sequence at its next grant.
- In non-strobe cycles, m_wr_ce_o and m_rd_ce_o are 0 and m_addr_o/m_data_o are 0.

## Timing
- All outputs are registered. Reset value of every output is 0, including rd_std_o and rd_fns_o. State resets to IDLE.
- Let N be the cycle a request is sampled high in IDLE.
- Offset:
  - m_wr_ce_o high in N+1..N+4 with NS, SC0, SC1, CTL addresses in that order.
  - ofs_ack_o in N+5.
  - GUARD N+5..N+4+GUARD_CYC; next grant can be sampled at N+5+GUARD_CYC.
- Increment: write in N+1, inc_ack_o in N+2, GUARD N+2..N+1+GUARD_CYC.
- Read:
  - m_rd_ce_o in N+1..N+3.
  - m_data_i sampled in N+2, N+3 and N+4.
  - rd_ack_o and new data in N+5.
- busy_o is high from N+1 through the last GUARD cycle.
- Simultaneous requests: the highest priority is served first. A lower request held high is served at the next IDLE sample; there is no starvation guarantee for rd under continuous ofs traffic.
- Asynchronous reset mid-sequence: the sequence is abandoned, no ack is issued, strobes drop immediately, and nothing remains pending after release.
- Only one strobe is ever high per cycle. m_wr_ce_o and m_rd_ce_o are never high together.

## Test plan
- Offset: ofs_sc=48'h0000_1234_5678, ofs_ns=32'h0000_03E8, intxms_sel=1 -> writes NS=0x3E8, SC0=0x00001234, SC1=0x00005678, CTL=0x00000005 in N+1..N+4; ofs_ack in N+5; busy low after 4 guard cycles.
- Increment: inc_val=0x0666_6666 -> one write to TICK_INC at N+1; inc_ack at N+2; no other strobes.
- Read: slave model returns 0xAAAA_0001, 0x2222_3333, 0x4444_5555 one cycle after each rd_ce -> rd_std_o=80'hAAAA0001_22223333_4444, rd_fns_o=16'h5555, rd_ack at N+5.
- Simultaneous: ofs, inc and rd raised in the same cycle and held -> order is offset, inc, read; consecutive sequences separated by exactly GUARD_CYC idle cycles; three acks, one each.
- Reset during OFS_SC0 -> all outputs 0 at once, no CTL write, no ofs_ack; after release with ofs_req low, the bus stays idle.
- Payload change after grant: ofs_ns changes at N+2 -> NS write still carries the value latched at N.

Source files
------------

// File: rtl/rtc_bus_seq.sv
// rtc_bus_seq: bus-master sequencer sharing the RTC register bank between
// the offset servo, the frequency loop (tick increment) and the time-read
// client. Each granted request becomes a fixed series of single-cycle
// bus2ip accesses, followed by a guard interval so that self-clearing
// control bits in the RTC have settled before the next sequence starts.
module rtc_bus_seq #(
  parameter logic [23:0] BASE           = 24'hA0_0000,
  // Idle cycles after every sequence; must be at least 3 to cover the
  // self-clear pipeline inside the RTC block.
  parameter int unsigned GUARD_CYC      = 4,
  // Register offsets inside the RTC block (ptpv2 register map).
  parameter logic [7:0]  RTC_CTL_ADDR   = 8'h00,
  parameter logic [7:0]  TICK_INC_ADDR  = 8'h08,
  parameter logic [7:0]  NS_OFST_ADDR   = 8'h0C,
  parameter logic [7:0]  SC_OFST_ADDR0  = 8'h10,
  parameter logic [7:0]  SC_OFST_ADDR1  = 8'h14,
  parameter logic [7:0]  CUR_TM_ADDR0   = 8'h20,
  parameter logic [7:0]  CUR_TM_ADDR1   = 8'h24,
  parameter logic [7:0]  CUR_TM_ADDR2   = 8'h28
) (
  input  logic         bus2ip_clk,
  input  logic         bus2ip_rst_n,
  // offset servo
  input  logic         ofs_req_i,
  input  logic [47:0]  ofs_sc_i,
  input  logic [31:0]  ofs_ns_i,
  input  logic         intxms_sel_i,
  output logic         ofs_ack_o,
  // frequency loop
  input  logic         inc_req_i,
  input  logic [31:0]  inc_val_i,
  output logic         inc_ack_o,
  // time-read client
  input  logic         rd_req_i,
  output logic         rd_ack_o,
  output logic [79:0]  rd_std_o,
  output logic [15:0]  rd_fns_o,
  // bus2ip master port
  output logic [31:0]  m_addr_o,
  output logic [31:0]  m_data_o,
  output logic         m_wr_ce_o,
  output logic         m_rd_ce_o,
  input  logic [31:0]  m_data_i,
  output logic         busy_o
);

  localparam int unsigned CNT_W = (GUARD_CYC > 2) ? $clog2(GUARD_CYC) : 2;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  typedef enum logic [3:0] {
    IDLE,
    OFS_NS,
    OFS_SC0,
    OFS_SC1,
    OFS_CTL,
    INC_WR,
    RD0,
    RD1,
    RD2,
    RD_CAP,
    GUARD
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   guard_cnt;

  // Grants are decided only in IDLE, fixed priority ofs > inc > rd.
  logic               gnt_ofs;
  logic               gnt_inc;
  logic               gnt_rd;

  // Payload captured at grant; the running sequence never looks at the
  // live request inputs again.
  logic [47:0]        ofs_sc_q;
  logic               intxms_q;

  // First two read words, held until the third arrives.
  logic [31:0]        tm_w0_q;
  logic [31:0]        tm_w1_q;

  // Full 32-bit bus address for a register offset in the RTC block.
  function automatic logic [31:0] reg_addr(input logic [7:0] ofs);
    return {BASE, ofs};
  endfunction

  // RTC_CTL word: intxms_sel plus the self-clearing offset-load bit.
  function automatic logic [31:0] ctl_word(input logic intxms);
    return {29'h0, intxms, 1'b0, 1'b1};
  endfunction

  // Fixed-priority arbitration, evaluated only while idle.
  always_comb begin
    gnt_ofs = 1'b0;
    gnt_inc = 1'b0;
    gnt_rd  = 1'b0;
    if (state == IDLE) begin
      if (ofs_req_i) begin
        gnt_ofs = 1'b1;
      end else if (inc_req_i) begin
        gnt_inc = 1'b1;
      end else if (rd_req_i) begin
        gnt_rd = 1'b1;
      end
    end
  end

  // Offset payload is frozen at grant (data path, no reset needed).
  always_ff @(posedge bus2ip_clk) begin
    if (gnt_ofs) begin
      ofs_sc_q <= ofs_sc_i;
      intxms_q <= intxms_sel_i;
    end
  end

  // Slave read data arrives one cycle after each strobe; park words 0 and 1.
  always_ff @(posedge bus2ip_clk) begin
    if (state == RD1) begin
      tm_w0_q <= m_data_i;
    end
    if (state == RD2) begin
      tm_w1_q <= m_data_i;
    end
  end

  // Sequencer FSM; every bus and handshake output is registered here so the
  // value for a state is launched on the edge that enters that state.
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state     <= IDLE;
      guard_cnt <= '0;
      m_addr_o  <= '0;
      m_data_o  <= '0;
      m_wr_ce_o <= 1'b0;
      m_rd_ce_o <= 1'b0;
      ofs_ack_o <= 1'b0;
      inc_ack_o <= 1'b0;
      rd_ack_o  <= 1'b0;
      rd_std_o  <= '0;
      rd_fns_o  <= '0;
      busy_o    <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle; bus lines idle at zero.
      m_addr_o  <= '0;
      m_data_o  <= '0;
      m_wr_ce_o <= 1'b0;
      m_rd_ce_o <= 1'b0;
      ofs_ack_o <= 1'b0;
      inc_ack_o <= 1'b0;
      rd_ack_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt_ofs) begin
            state     <= OFS_NS;
            busy_o    <= 1'b1;
            m_wr_ce_o <= 1'b1;
            m_addr_o  <= reg_addr(NS_OFST_ADDR);
            m_data_o  <= ofs_ns_i;
          end else if (gnt_inc) begin
            state     <= INC_WR;
            busy_o    <= 1'b1;
            m_wr_ce_o <= 1'b1;
            m_addr_o  <= reg_addr(TICK_INC_ADDR);
            m_data_o  <= inc_val_i;
          end else if (gnt_rd) begin
            state     <= RD0;
            busy_o    <= 1'b1;
            m_rd_ce_o <= 1'b1;
            m_addr_o  <= reg_addr(CUR_TM_ADDR0);
          end
        end

        OFS_NS: begin
          state     <= OFS_SC0;
          m_wr_ce_o <= 1'b1;
          m_addr_o  <= reg_addr(SC_OFST_ADDR0);
          m_data_o  <= ofs_sc_q[47:16];
        end

        OFS_SC0: begin
          state     <= OFS_SC1;
          m_wr_ce_o <= 1'b1;
          m_addr_o  <= reg_addr(SC_OFST_ADDR1);
          m_data_o  <= {16'h0, ofs_sc_q[15:0]};
        end

        OFS_SC1: begin
          state     <= OFS_CTL;
          m_wr_ce_o <= 1'b1;
          m_addr_o  <= reg_addr(RTC_CTL_ADDR);
          m_data_o  <= ctl_word(intxms_q);
        end

        OFS_CTL: begin
          state     <= GUARD;
          guard_cnt <= '0;
          ofs_ack_o <= 1'b1;
        end

        INC_WR: begin
          state     <= GUARD;
          guard_cnt <= '0;
          inc_ack_o <= 1'b1;
        end

        RD0: begin
          state     <= RD1;
          m_rd_ce_o <= 1'b1;
          m_addr_o  <= reg_addr(CUR_TM_ADDR1);
        end

        RD1: begin
          state     <= RD2;
          m_rd_ce_o <= 1'b1;
          m_addr_o  <= reg_addr(CUR_TM_ADDR2);
        end

        RD2: begin
          state <= RD_CAP;
        end

        // Third word is on m_data_i now; publish the whole snapshot at once.
        RD_CAP: begin
          state     <= GUARD;
          guard_cnt <= '0;
          rd_ack_o  <= 1'b1;
          rd_std_o  <= {tm_w0_q, tm_w1_q, m_data_i[31:16]};
          rd_fns_o  <= m_data_i[15:0];
        end

        GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// tb_rtc_bus_seq: directed and randomized bench for rtc_bus_seq. A timeline
// model predicts, per clock period, every bus access, ack, busy level and
// captured read snapshot from the sequence timings; one checker compares the
// DUT against it on every falling edge.
module tb_rtc_bus_seq;

  localparam int          G      = 4;
  localparam logic [23:0] BASE   = 24'h5A_C300;
  localparam logic [7:0]  A_CTL  = 8'h40;
  localparam logic [7:0]  A_TICK = 8'h44;
  localparam logic [7:0]  A_NS   = 8'h48;
  localparam logic [7:0]  A_SC0  = 8'h4C;
  localparam logic [7:0]  A_SC1  = 8'h50;
  localparam logic [7:0]  A_TM0  = 8'h60;
  localparam logic [7:0]  A_TM1  = 8'h64;
  localparam logic [7:0]  A_TM2  = 8'h68;
  localparam int          MAXC   = 4096;
  localparam int          NW     = 1024;

  logic        clk;
  logic        rst_n;
  logic        ofs_req;
  logic [47:0] ofs_sc;
  logic [31:0] ofs_ns;
  logic        intxms;
  logic        ofs_ack;
  logic        inc_req;
  logic [31:0] inc_val;
  logic        inc_ack;
  logic        rd_req;
  logic        rd_ack;
  logic [79:0] rd_std;
  logic [15:0] rd_fns;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wr_ce;
  logic        m_rd_ce;
  logic [31:0] m_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rtc_bus_seq #(
    .BASE(BASE), .GUARD_CYC(G),
    .RTC_CTL_ADDR(A_CTL), .TICK_INC_ADDR(A_TICK), .NS_OFST_ADDR(A_NS),
    .SC_OFST_ADDR0(A_SC0), .SC_OFST_ADDR1(A_SC1),
    .CUR_TM_ADDR0(A_TM0), .CUR_TM_ADDR1(A_TM1), .CUR_TM_ADDR2(A_TM2)
  ) dut (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n),
    .ofs_req_i(ofs_req), .ofs_sc_i(ofs_sc), .ofs_ns_i(ofs_ns),
    .intxms_sel_i(intxms), .ofs_ack_o(ofs_ack),
    .inc_req_i(inc_req), .inc_val_i(inc_val), .inc_ack_o(inc_ack),
    .rd_req_i(rd_req), .rd_ack_o(rd_ack), .rd_std_o(rd_std), .rd_fns_o(rd_fns),
    .m_addr_o(m_addr), .m_data_o(m_wdata), .m_wr_ce_o(m_wr_ce),
    .m_rd_ce_o(m_rd_ce), .m_data_i(m_rdata), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [65:0] bus_now();
    return {m_wr_ce, m_rd_ce, m_addr, m_wdata};
  endfunction

  function automatic logic [65:0] bus_wr(input logic [7:0] a, input logic [31:0] d);
    return {1'b1, 1'b0, BASE, a, d};
  endfunction

  function automatic logic [65:0] bus_rd(input logic [7:0] a);
    return {1'b0, 1'b1, BASE, a, 32'h0};
  endfunction

  // ---------------- slave model ----------------
  bit [31:0] slv_words[NW];
  int        sk = 0;

  always @(posedge clk) begin
    if (m_rd_ce) begin
      m_rdata <= slv_words[sk % NW];
      sk      <= sk + 1;
    end else begin
      m_rdata <= $urandom;
    end
  end

  // ---------------- timeline model ----------------
  // Index = clock period following posedge number idx.
  bit        e_wr[MAXC];
  bit        e_rd[MAXC];
  bit [31:0] e_addr[MAXC];
  bit [31:0] e_data[MAXC];
  bit        e_oack[MAXC];
  bit        e_iack[MAXC];
  bit        e_rack[MAXC];
  bit        e_busy[MAXC];
  bit        e_upd[MAXC];
  bit [79:0] e_std[MAXC];
  bit [15:0] e_fns[MAXC];
  int        cyc = 0;
  int        free_at = 0;
  int        mk = 0;

  function automatic void put_acc(input int c, input bit wr, input logic [7:0] a,
                                  input logic [31:0] d);
    e_wr[c]   = wr;
    e_rd[c]   = !wr;
    e_addr[c] = {BASE, a};
    e_data[c] = d;
  endfunction

  function automatic void put_busy(input int from, input int upto);
    for (int c = from; c <= upto; c++) e_busy[c] = 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && cyc >= free_at && cyc + 2 * G + 8 < MAXC) begin
      if (ofs_req) begin
        put_acc(cyc,     1'b1, A_NS,  ofs_ns);
        put_acc(cyc + 1, 1'b1, A_SC0, ofs_sc[47:16]);
        put_acc(cyc + 2, 1'b1, A_SC1, {16'h0, ofs_sc[15:0]});
        put_acc(cyc + 3, 1'b1, A_CTL, {29'h0, intxms, 2'b01});
        e_oack[cyc + 4] = 1'b1;
        put_busy(cyc, cyc + 3 + G);
        free_at = cyc + 5 + G;
      end else if (inc_req) begin
        put_acc(cyc, 1'b1, A_TICK, inc_val);
        e_iack[cyc + 1] = 1'b1;
        put_busy(cyc, cyc + G);
        free_at = cyc + 2 + G;
      end else if (rd_req) begin
        put_acc(cyc,     1'b0, A_TM0, 32'h0);
        put_acc(cyc + 1, 1'b0, A_TM1, 32'h0);
        put_acc(cyc + 2, 1'b0, A_TM2, 32'h0);
        e_rack[cyc + 4] = 1'b1;
        e_upd[cyc + 4]  = 1'b1;
        e_std[cyc + 4]  = {slv_words[mk % NW], slv_words[(mk + 1) % NW],
                           slv_words[(mk + 2) % NW][31:16]};
        e_fns[cyc + 4]  = slv_words[(mk + 2) % NW][15:0];
        mk = mk + 3;
        put_busy(cyc, cyc + 3 + G);
        free_at = cyc + 5 + G;
      end
    end
  end

  // Reset abandons everything scheduled from the current period on.
  always @(negedge rst_n) begin
    for (int c = cyc; c < MAXC; c++) begin
      e_wr[c] = 0; e_rd[c] = 0; e_addr[c] = 0; e_data[c] = 0;
      e_oack[c] = 0; e_iack[c] = 0; e_rack[c] = 0; e_busy[c] = 0; e_upd[c] = 0;
    end
    free_at = 0;
  end

  // ---------------- compare process ----------------
  logic [79:0] h_std = '0;
  logic [15:0] h_fns = '0;

  always @(negedge clk) begin
    logic [65:0] x_bus;
    logic [3:0]  x_ctl;
    if (!rst_n) begin
      x_bus = '0;
      x_ctl = '0;
      h_std = '0;
      h_fns = '0;
    end else begin
      x_bus = {e_wr[cyc], e_rd[cyc], e_addr[cyc], e_data[cyc]};
      x_ctl = {e_oack[cyc], e_iack[cyc], e_rack[cyc], e_busy[cyc]};
      if (e_upd[cyc]) begin
        h_std = e_std[cyc];
        h_fns = e_fns[cyc];
      end
    end
    check("model_bus", bus_now(), x_bus);
    check("model_ctl", {ofs_ack, inc_ack, rd_ack, busy}, x_ctl);
    check("model_rdout", {rd_std, rd_fns}, {h_std, h_fns});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t_ofs, t_inc, t_rd, cnt;
    bit d_ofs, d_inc, d_rd;

    slv_words[0] = 32'hAAAA_0001;
    slv_words[1] = 32'h2222_3333;
    slv_words[2] = 32'h4444_5555;
    for (int i = 3; i < NW; i++) slv_words[i] = $urandom;

    rst_n = 1'b0; ofs_req = 0; inc_req = 0; rd_req = 0;
    ofs_sc = '0; ofs_ns = '0; intxms = 0; inc_val = '0;
    idle_steps(3);
    @(negedge clk);
    check("reset_ctl", {ofs_ack, inc_ack, rd_ack, busy, m_wr_ce, m_rd_ce}, 6'h0);
    check("reset_rdout", {rd_std, rd_fns}, 96'h0);
    step();
    #2 rst_n = 1'b1;
    idle_steps(2);

    // Offset sequence with payload changes after grant.
    ofs_sc = 48'h0000_1234_5678; ofs_ns = 32'h0000_03E8; intxms = 1'b1; ofs_req = 1'b1;
    @(negedge clk);
    check("ofs_pre_busy", busy, 1'b0);
    step(); ofs_sc = 48'hFFFF_EEEE_DDDD;
    @(negedge clk); check("ofs_ns_wr", bus_now(), bus_wr(A_NS, 32'h0000_03E8));
    step(); ofs_ns = 32'hDEAD_BEEF; intxms = 1'b0;
    @(negedge clk); check("ofs_sc0_wr", bus_now(), bus_wr(A_SC0, 32'h0000_1234));
    step();
    @(negedge clk); check("ofs_sc1_wr", bus_now(), bus_wr(A_SC1, 32'h0000_5678));
    step();
    @(negedge clk); check("ofs_ctl_wr", bus_now(), bus_wr(A_CTL, 32'h0000_0005));
    step();
    @(negedge clk); check("ofs_ack", {ofs_ack, m_wr_ce, busy}, 3'b101);
    step(); ofs_req = 1'b0;
    idle_steps(2);
    @(negedge clk); check("ofs_guard_busy", busy, 1'b1);
    step();
    @(negedge clk); check("ofs_idle", busy, 1'b0);
    idle_steps(2);

    // Increment sequence.
    inc_val = 32'h0666_6666; inc_req = 1'b1;
    step();
    @(negedge clk); check("inc_wr", bus_now(), bus_wr(A_TICK, 32'h0666_6666));
    step();
    @(negedge clk); check("inc_ack", {inc_ack, bus_now()}, {1'b1, 66'h0});
    step(); inc_req = 1'b0;
    idle_steps(G + 2);

    // Read sequence against the literal slave words.
    rd_req = 1'b1;
    step();
    @(negedge clk); check("rd0", bus_now(), bus_rd(A_TM0));
    idle_steps(4);
    @(negedge clk);
    check("rd_ack", rd_ack, 1'b1);
    check("rd_std", rd_std, 80'hAAAA0001_22223333_4444);
    check("rd_fns", rd_fns, 16'h5555);
    step(); rd_req = 1'b0;
    idle_steps(G + 2);

    // Simultaneous requests, each held until its own ack.
    ofs_req = 1; inc_req = 1; rd_req = 1;
    ofs_sc = 48'h0000_0000_0042; ofs_ns = 32'h1; inc_val = 32'h0666_6000;
    t_ofs = -1; t_inc = -1; t_rd = -1; d_ofs = 0; d_inc = 0; d_rd = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (d_ofs) ofs_req = 1'b0;
      if (d_inc) inc_req = 1'b0;
      if (d_rd)  rd_req  = 1'b0;
      @(negedge clk);
      if (ofs_ack) begin t_ofs = i; d_ofs = 1; end
      if (inc_ack) begin t_inc = i; d_inc = 1; end
      if (rd_ack)  begin t_rd  = i; d_rd  = 1; end
    end
    check("sim_ofs_ack_cyc", t_ofs, 5);
    check("sim_inc_ack_cyc", t_inc, 11);
    check("sim_rd_ack_cyc", t_rd, 20);
    ofs_req = 0; inc_req = 0; rd_req = 0;
    idle_steps(4);

    // Reset in the middle of the offset sequence (during OFS_SC0).
    ofs_sc = 48'h0000_1234_5678; ofs_ns = 32'h3E8; intxms = 1; ofs_req = 1'b1;
    step();
    step();
    #1 rst_n = 1'b0; ofs_req = 1'b0;
    #1;
    check("rst_bus", bus_now(), 66'h0);
    check("rst_ctl", {ofs_ack, inc_ack, rd_ack, busy}, 4'h0);
    check("rst_rdout", {rd_std, rd_fns}, 96'h0);
    idle_steps(2);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_wr_ce || m_rd_ce || ofs_ack || inc_ack || rd_ack || busy) cnt++;
    end
    check("rst_quiet", cnt, 0);

    // Randomized traffic: sticky request levels, payload churn every cycle.
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) ofs_req = ~ofs_req;
      if ($urandom_range(0, 3) == 0) inc_req = ~inc_req;
      if ($urandom_range(0, 3) == 0) rd_req  = ~rd_req;
      ofs_sc  = {16'($urandom), 32'($urandom)};
      ofs_ns  = $urandom;
      inc_val = $urandom;
      intxms  = 1'($urandom);
    end
    ofs_req = 0; inc_req = 0; rd_req = 0;
    idle_steps(2 * G + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
